// File: rtl/quadratic_pkg.sv
// Shared definitions for the quadratic solver / coefficient generator pair:
// state encoding, result codes, widths and the 5-bit sign-magnitude format.
package quadratic_pkg;

  localparam int unsigned MUL_STEPS  = 4;
  localparam int unsigned MAG_MAX    = 15;
  localparam int unsigned IN_W       = 4;
  localparam int unsigned SUM_W      = IN_W + 1;
  localparam int unsigned MCAND_W    = 8;
  localparam int unsigned MPLIER_W   = MUL_STEPS;
  localparam int unsigned PROD_W     = 12;
  localparam int unsigned STEP_CNT_W = 3;
  localparam int unsigned SM_MAG_W   = 4;
  localparam int unsigned SM_W       = SM_MAG_W + 1;
  localparam int unsigned RES_W      = 2;

  typedef logic [RES_W-1:0] result_t;

  localparam result_t RES_IDLE    = 2'b00;
  localparam result_t RES_INVALID = 2'b01;
  localparam result_t RES_OK      = 2'b10;
  localparam result_t RES_SAT     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL_B,
    ST_MUL_P,
    ST_MUL_C,
    ST_PACK,
    ST_DONE
  } state_t;

  // Sign in bit 4, magnitude in bits [3:0].
  typedef struct packed {
    logic                sign;
    logic [SM_MAG_W-1:0] mag;
  } sm_t;

  function automatic logic mag_sat(input logic [PROD_W-1:0] mag);
    return mag > PROD_W'(MAG_MAX);
  endfunction

  // Clamp to MAG_MAX and never produce a negative zero.
  function automatic sm_t to_sm(input logic neg, input logic [PROD_W-1:0] mag);
    sm_t r;
    r.mag  = mag_sat(mag) ? SM_MAG_W'(MAG_MAX) : mag[SM_MAG_W-1:0];
    r.sign = neg && (mag != '0);
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_u.sv
// Unsigned shift-add multiplier: load performs the first partial-sum update,
// each step performs one more, done rises after MUL_STEPS updates.
module seq_mult_u
  import quadratic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [MCAND_W-1:0]  mcand,
  input  logic [MPLIER_W-1:0] mplier,
  output logic [PROD_W-1:0]   product,
  output logic                done,
  output logic                last_c
);

  logic [PROD_W-1:0]     acc_q;
  logic [PROD_W-1:0]     mc_sh_q;
  logic [MPLIER_W-1:0]   mp_sh_q;
  logic [STEP_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mc_sh_q <= '0;
      mp_sh_q <= '0;
      cnt_q   <= STEP_CNT_W'(MUL_STEPS);
      done    <= 1'b1;
    end else if (load) begin
      acc_q   <= mplier[0] ? PROD_W'(mcand) : '0;
      mc_sh_q <= PROD_W'(mcand) << 1;
      mp_sh_q <= mplier >> 1;
      cnt_q   <= STEP_CNT_W'(1);
      done    <= 1'b0;
    end else if (step && !done) begin
      acc_q   <= acc_q + (mp_sh_q[0] ? mc_sh_q : '0);
      mc_sh_q <= mc_sh_q << 1;
      mp_sh_q <= mp_sh_q >> 1;
      cnt_q   <= cnt_q + STEP_CNT_W'(1);
      done    <= (cnt_q == STEP_CNT_W'(MUL_STEPS - 1));
    end
  end

  assign product = acc_q;
  assign last_c  = !done && (cnt_q == STEP_CNT_W'(MUL_STEPS - 1));

endmodule

// File: rtl/quadratic_coeff_gen.sv
// Builds b = -a(x1+x2) and c = a*x1*x2 from a and two integer roots and emits
// a, b, c in sign-magnitude form, sharing one sequential multiplier.
module quadratic_coeff_gen
  import quadratic_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [IN_W-1:0]   i_a,
  input  logic [IN_W-1:0]   i_x1,
  input  logic [IN_W-1:0]   i_x2,
  output logic              o_busy,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result,
  output logic [SM_W-1:0]   o_a,
  output logic [SM_W-1:0]   o_b,
  output logic [SM_W-1:0]   o_c
);

  state_t              state_q, state_d;
  logic [IN_W-1:0]     a_q, x1_q, x2_q;
  logic [PROD_W-1:0]   p1_q;

  logic [SUM_W-1:0]    sum_c, mag_sum_c;
  logic [IN_W-1:0]     mag_a_c, mag_x1_c, mag_x2_c;
  logic                neg_b_c, neg_c_c;

  logic                in_mul_c, mul_load_c, mul_step_c, mul_done, mul_last_c;
  logic [MCAND_W-1:0]  mcand_c;
  logic [MPLIER_W-1:0] mplier_c;
  logic [PROD_W-1:0]   mul_product;

  sm_t                 a_sm_c, b_sm_c, c_sm_c;
  logic                sat_c;

  logic                busy_d, valid_d;
  logic [RES_W-1:0]    result_d;
  logic [SM_W-1:0]     a_d, b_d, c_d;

  // Operand decode from the captured two's-complement values.
  assign sum_c     = {x1_q[IN_W-1], x1_q} + {x2_q[IN_W-1], x2_q};
  assign mag_sum_c = sum_c[SUM_W-1] ? (~sum_c + SUM_W'(1)) : sum_c;
  assign mag_a_c   = a_q[IN_W-1]  ? (~a_q  + IN_W'(1)) : a_q;
  assign mag_x1_c  = x1_q[IN_W-1] ? (~x1_q + IN_W'(1)) : x1_q;
  assign mag_x2_c  = x2_q[IN_W-1] ? (~x2_q + IN_W'(1)) : x2_q;
  assign neg_b_c   = ~(a_q[IN_W-1] ^ sum_c[SUM_W-1]);
  assign neg_c_c   = a_q[IN_W-1] ^ x1_q[IN_W-1] ^ x2_q[IN_W-1];

  // Multiplier idles with done set, so the first cycle of each multiply
  // state loads and the rest step; P2 is fed straight back for P3.
  assign in_mul_c   = (state_q == ST_MUL_B) || (state_q == ST_MUL_P) || (state_q == ST_MUL_C);
  assign mul_load_c = in_mul_c && mul_done;
  assign mul_step_c = in_mul_c && !mul_done;

  always_comb begin
    mcand_c  = '0;
    mplier_c = '0;
    case (state_q)
      ST_MUL_B: begin
        mcand_c  = MCAND_W'(mag_sum_c);
        mplier_c = mag_a_c;
      end
      ST_MUL_P: begin
        mcand_c  = MCAND_W'(mag_x1_c);
        mplier_c = mag_x2_c;
      end
      ST_MUL_C: begin
        mcand_c  = mul_product[MCAND_W-1:0];
        mplier_c = mag_a_c;
      end
      default: ;
    endcase
  end

  seq_mult_u u_mult (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (mul_load_c),
    .step    (mul_step_c),
    .mcand   (mcand_c),
    .mplier  (mplier_c),
    .product (mul_product),
    .done    (mul_done),
    .last_c  (mul_last_c)
  );

  assign a_sm_c = to_sm(a_q[IN_W-1], PROD_W'(mag_a_c));
  assign b_sm_c = to_sm(neg_b_c, p1_q);
  assign c_sm_c = to_sm(neg_c_c, mul_product);
  assign sat_c  = mag_sat(p1_q) || mag_sat(mul_product);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q  <= '0;
      x1_q <= '0;
      x2_q <= '0;
      p1_q <= '0;
    end else begin
      if (state_q == ST_IDLE && i_start) begin
        a_q  <= i_a;
        x1_q <= i_x1;
        x2_q <= i_x2;
      end
      if (state_q == ST_MUL_P && mul_done) begin
        p1_q <= mul_product;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = o_result;
    a_d      = o_a;
    b_d      = o_b;
    c_d      = o_c;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (a_q == '0) begin
          state_d  = ST_DONE;
          result_d = RES_INVALID;
          a_d      = '0;
          b_d      = '0;
          c_d      = '0;
        end else begin
          state_d  = ST_MUL_B;
        end
      end
      ST_MUL_B: if (mul_last_c) state_d = ST_MUL_P;
      ST_MUL_P: if (mul_last_c) state_d = ST_MUL_C;
      ST_MUL_C: if (mul_last_c) state_d = ST_PACK;
      ST_PACK: begin
        state_d  = ST_DONE;
        a_d      = a_sm_c;
        b_d      = b_sm_c;
        c_d      = c_sm_c;
        result_d = sat_c ? RES_SAT : RES_OK;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= RES_IDLE;
      o_a      <= '0;
      o_b      <= '0;
      o_c      <= '0;
    end else begin
      state_q  <= state_d;
      o_busy   <= busy_d;
      o_valid  <= valid_d;
      o_result <= result_d;
      o_a      <= a_d;
      o_b      <= b_d;
      o_c      <= c_d;
    end
  end

endmodule

// File: tb/tb_quadratic_coeff_gen.sv
// Randomized and directed bench for quadratic_coeff_gen against an integer
// arithmetic model of the coefficients, encoding and handshake timing.
module tb_quadratic_coeff_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, x1, x2;
  logic       busy, valid;
  logic [1:0] result;
  logic [4:0] oa, ob, oc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  quadratic_coeff_gen dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_a      (a),
    .i_x1     (x1),
    .i_x2     (x2),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result),
    .o_a      (oa),
    .o_b      (ob),
    .o_c      (oc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sv4(input logic [3:0] v);
    return int'({{28{v[3]}}, v});
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Sign-magnitude with clamp at 15; a negative value always has m >= 1.
  function automatic logic [4:0] enc(input int v);
    int m;
    m = iabs(v);
    if (m > 15) m = 15;
    return {(v < 0) ? 1'b1 : 1'b0, 4'(m)};
  endfunction

  // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
  // spur > 0 fires an extra start with random operands at that cycle.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tx1,
                        input logic [3:0] tx2, input int spur);
    int av, bv, cv, lat_exp;
    logic [4:0] ea, eb, ec;
    logic [1:0] eres;
    bit seen;
    av = sv4(ta);
    bv = -av * (sv4(tx1) + sv4(tx2));
    cv = av * sv4(tx1) * sv4(tx2);
    if (av == 0) begin
      ea = '0; eb = '0; ec = '0; eres = 2'b01; lat_exp = 2;
    end else begin
      ea = enc(av); eb = enc(bv); ec = enc(cv);
      eres = (iabs(bv) > 15 || iabs(cv) > 15) ? 2'b11 : 2'b10;
      lat_exp = 15;
    end
    a = ta; x1 = tx1; x2 = tx2; start = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      start = (k == spur);
      if (k == spur) begin
        a = 4'($urandom); x1 = 4'($urandom); x2 = 4'($urandom);
      end
      if (k == 1) check("busy_cycle1", 32'(busy), 1);
      if (valid) begin
        seen = 1'b1;
        check("latency", k, lat_exp);
        check("o_a", 32'(oa), 32'(ea));
        check("o_b", 32'(ob), 32'(eb));
        check("o_c", 32'(oc), 32'(ec));
        check("o_result", 32'(result), 32'(eres));
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    check("valid_one_cycle", 32'(valid), 0);
    check("busy_cleared", 32'(busy), 0);
    check("hold_o_c", 32'(oc), 32'(ec));
    check("hold_result", 32'(result), 32'(eres));
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1; start = 1'b0; a = '0; x1 = '0; x2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_abc", 32'({oa, ob, oc}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd1, 4'd2, 4'd3, -1);
    run_op(4'd0, 4'd5, 4'd1, -1);
    run_op(4'h8, 4'h8, 4'h8, -1);
    run_op(4'd1, 4'd3, 4'hD, -1);
    run_op(4'd1, 4'd2, 4'd3, 5);
    run_op(4'h9, 4'd7, 4'h8, -1);

    // Reset in the middle of a multiply aborts and clears everything.
    a = 4'd2; x1 = 4'd3; x2 = 4'd1; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_result", 32'(result), 0);
    check("abort_abc", 32'({oa, ob, oc}), 0);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 32'(seen_valid), 0);
    run_op(4'd2, 4'd3, 4'd1, -1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] ra, rx1, rx2;
      int sp;
      ra = 4'($urandom); rx1 = 4'($urandom); rx2 = 4'($urandom);
      sp = -1;
      if ($urandom_range(0, 1) == 1) sp = (ra == 4'd0) ? 1 : int'($urandom_range(1, 14));
      run_op(ra, rx1, rx2, sp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
